// File: rtl/alarm_snooze_ctrl.sv
// Alarm clock sequencer: arms, rings on hh:mm:00 match, snoozes and times out.
// Optional ALARM_BEEP_PATTERN_EN makes the buzzer toggle every second while ringing.
module alarm_snooze_ctrl #(
    parameter int SNOOZE_MIN   = 5,
    parameter int RING_TIMEOUT = 60,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  hr_24,
    input  logic [5:0]  min,
    input  logic [5:0]  sec,
    input  logic [4:0]  alarm_hr,
    input  logic [5:0]  alarm_min,
    input  logic        alarm_en,
    input  logic        snooze_btn,
    input  logic        stop_btn,
    output logic        buzzer,
    output logic [1:0]  state,
    output logic [2:0]  snooze_cnt,
    output logic [11:0] snooze_left
);

    localparam logic [11:0] SNOOZE_LOAD  = 12'(SNOOZE_MIN * 60);
    localparam logic [11:0] RING_LAST    = 12'(RING_TIMEOUT - 1);
    localparam logic [2:0]  SNOOZE_LIMIT = 3'(MAX_SNOOZE);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_RINGING = 2'b10,
        S_SNOOZE  = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic        buzzer_q, buzzer_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [11:0] left_q, left_d;
    logic [11:0] ring_q, ring_d;
    logic        match;
    logic        can_snooze;
    logic        enter_ring;
    logic        stay_ring;
`ifdef ALARM_BEEP_PATTERN_EN
    logic        phase_q, phase_d;
`endif

    assign match      = (hr_24 == alarm_hr) && (min == alarm_min) && (sec == 6'd0);
    assign can_snooze = (cnt_q < SNOOZE_LIMIT);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        left_d     = left_q;
        ring_d     = ring_q;
        enter_ring = 1'b0;
        stay_ring  = 1'b0;
        if (!alarm_en) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            left_d  = 12'd0;
            ring_d  = 12'd0;
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_ARMED;
                S_ARMED: begin
                    if (match) begin
                        state_d    = S_RINGING;
                        cnt_d      = 3'd0;
                        ring_d     = 12'd0;
                        enter_ring = 1'b1;
                    end
                end
                S_RINGING: begin
                    ring_d = ring_q + 12'd1;
                    // A timeout behaves like whichever button the snooze budget allows.
                    if (stop_btn || (ring_q == RING_LAST && !can_snooze)) begin
                        state_d = S_ARMED;
                        cnt_d   = 3'd0;
                    end else if ((snooze_btn || ring_q == RING_LAST) && can_snooze) begin
                        state_d = S_SNOOZE;
                        left_d  = SNOOZE_LOAD;
                        cnt_d   = cnt_q + 3'd1;
                    end else begin
                        stay_ring = 1'b1;
                    end
                end
                S_SNOOZE: begin
                    if (stop_btn) begin
                        state_d = S_ARMED;
                        left_d  = 12'd0;
                        cnt_d   = 3'd0;
                    end else if (left_q == 12'd1) begin
                        state_d    = S_RINGING;
                        left_d     = 12'd0;
                        ring_d     = 12'd0;
                        enter_ring = 1'b1;
                    end else begin
                        left_d = left_q - 12'd1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

`ifdef ALARM_BEEP_PATTERN_EN
    always_comb begin
        phase_d = 1'b0;
        if (enter_ring)
            phase_d = 1'b1;
        else if (stay_ring)
            phase_d = ~phase_q;
        buzzer_d = phase_d;
    end
`else
    assign buzzer_d = enter_ring | stay_ring;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            buzzer_q <= 1'b0;
            cnt_q    <= 3'd0;
            left_q   <= 12'd0;
            ring_q   <= 12'd0;
        end else begin
            state_q  <= state_d;
            buzzer_q <= buzzer_d;
            cnt_q    <= cnt_d;
            left_q   <= left_d;
            ring_q   <= ring_d;
        end
    end

`ifdef ALARM_BEEP_PATTERN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            phase_q <= 1'b0;
        else
            phase_q <= phase_d;
    end
`endif

    assign buzzer      = buzzer_q;
    assign state       = state_q;
    assign snooze_cnt  = cnt_q;
    assign snooze_left = left_q;

endmodule

// File: tb/tb_alarm_snooze_ctrl.sv
// Directed bench for alarm_snooze_ctrl; main instance uses short snooze/timeout,
// a second instance with a 3-minute snooze covers the mid-snooze reset case.
module tb_alarm_snooze_ctrl;

`ifdef ALARM_BEEP_PATTERN_EN
    localparam bit PAT = 1'b1;
`else
    localparam bit PAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  hr_24, alarm_hr;
    logic [5:0]  min, sec, alarm_min;
    logic        alarm_en, snooze_btn, stop_btn;
    logic        alarm_en2, snooze_btn2, stop_btn2;
    logic        buzzer, buzzer2;
    logic [1:0]  state, state2;
    logic [2:0]  snooze_cnt, snooze_cnt2;
    logic [11:0] snooze_left, snooze_left2;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alarm_snooze_ctrl #(.SNOOZE_MIN(1), .RING_TIMEOUT(10), .MAX_SNOOZE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .hr_24(hr_24), .min(min), .sec(sec),
        .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_en(alarm_en),
        .snooze_btn(snooze_btn), .stop_btn(stop_btn), .buzzer(buzzer),
        .state(state), .snooze_cnt(snooze_cnt), .snooze_left(snooze_left)
    );

    alarm_snooze_ctrl #(.SNOOZE_MIN(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .hr_24(hr_24), .min(min), .sec(sec),
        .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_en(alarm_en2),
        .snooze_btn(snooze_btn2), .stop_btn(stop_btn2), .buzzer(buzzer2),
        .state(state2), .snooze_cnt(snooze_cnt2), .snooze_left(snooze_left2)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_time(input logic [5:0] m, input logic [5:0] s);
        hr_24 = 5'd7;
        min   = m;
        sec   = s;
    endtask

    initial begin
        rst_n = 1'b0;
        alarm_en = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
        alarm_en2 = 1'b0; snooze_btn2 = 1'b0; stop_btn2 = 1'b0;
        alarm_hr = 5'd7; alarm_min = 6'd30;
        set_time(6'd29, 6'd58);
        #3;
        chk("reset_state", 12'(state), 12'd0);
        chk("reset_buzzer", 12'(buzzer), 12'd0);
        chk("reset_cnt", 12'(snooze_cnt), 12'd0);
        chk("reset_left", snooze_left, 12'd0);
        #9 rst_n = 1'b1;

        step();
        chk("idle_hold", 12'(state), 12'd0);
        alarm_en = 1'b1;
        step();
        chk("arm", 12'(state), 12'd1);

        // ring on 07:30:00, then four ringing edges for the beep pattern
        set_time(6'd29, 6'd59);
        step();
        chk("armed_no_match", 12'(state), 12'd1);
        set_time(6'd30, 6'd0);
        step();
        chk("ring_state", 12'(state), 12'd2);
        chk("ring_buzz0", 12'(buzzer), 12'd1);
        set_time(6'd30, 6'd1);
        step();
        chk("ring_still", 12'(state), 12'd2);
        chk("ring_buzz1", 12'(buzzer), PAT ? 12'd0 : 12'd1);
        step();
        chk("ring_buzz2", 12'(buzzer), 12'd1);
        step();
        chk("ring_buzz3", 12'(buzzer), PAT ? 12'd0 : 12'd1);

        snooze_btn = 1'b1;
        step();
        chk("snz_state", 12'(state), 12'd3);
        chk("snz_left", snooze_left, 12'd60);
        chk("snz_cnt", 12'(snooze_cnt), 12'd1);
        chk("snz_buzz", 12'(buzzer), 12'd0);
        step();
        chk("snz_btn_ignored", snooze_left, 12'd59);
        chk("snz_btn_state", 12'(state), 12'd3);
        snooze_btn = 1'b0;
        steps(58);
        chk("snz_left1", snooze_left, 12'd1);
        step();
        chk("reringing", 12'(state), 12'd2);
        chk("reringing_buzz", 12'(buzzer), 12'd1);
        chk("reringing_left", snooze_left, 12'd0);
        chk("reringing_cnt", 12'(snooze_cnt), 12'd1);

        // snooze budget used up: button ignored, timeout acts as stop
        snooze_btn = 1'b1;
        step();
        chk("limit_state", 12'(state), 12'd2);
        chk("limit_buzz", 12'(buzzer), PAT ? 12'd0 : 12'd1);
        chk("limit_cnt", 12'(snooze_cnt), 12'd1);
        snooze_btn = 1'b0;
        steps(8);
        chk("timeout_pre", 12'(state), 12'd2);
        step();
        chk("timeout_state", 12'(state), 12'd1);
        chk("timeout_buzz", 12'(buzzer), 12'd0);
        chk("timeout_cnt", 12'(snooze_cnt), 12'd0);

        // stop and snooze together
        set_time(6'd30, 6'd0);
        step();
        chk("ring2", 12'(state), 12'd2);
        set_time(6'd30, 6'd1);
        stop_btn = 1'b1; snooze_btn = 1'b1;
        step();
        chk("both_state", 12'(state), 12'd1);
        chk("both_cnt", 12'(snooze_cnt), 12'd0);
        chk("both_left", snooze_left, 12'd0);
        stop_btn = 1'b0; snooze_btn = 1'b0;

        // stop during snooze
        set_time(6'd30, 6'd0);
        step();
        set_time(6'd30, 6'd1);
        snooze_btn = 1'b1;
        step();
        chk("snz2_state", 12'(state), 12'd3);
        snooze_btn = 1'b0; stop_btn = 1'b1;
        step();
        chk("snzstop_state", 12'(state), 12'd1);
        chk("snzstop_left", snooze_left, 12'd0);
        chk("snzstop_cnt", 12'(snooze_cnt), 12'd0);
        stop_btn = 1'b0;

        // disarm while ringing
        set_time(6'd30, 6'd0);
        step();
        chk("ring3", 12'(state), 12'd2);
        set_time(6'd30, 6'd1);
        alarm_en = 1'b0;
        step();
        chk("disarm_state", 12'(state), 12'd0);
        chk("disarm_buzz", 12'(buzzer), 12'd0);

        // second instance: reset while snoozing with 123 s remaining
        alarm_en2 = 1'b1;
        step();
        chk("d2_arm", 12'(state2), 12'd1);
        set_time(6'd30, 6'd0);
        step();
        chk("d2_ring", 12'(state2), 12'd2);
        set_time(6'd30, 6'd1);
        snooze_btn2 = 1'b1;
        step();
        chk("d2_snz_left", snooze_left2, 12'd180);
        snooze_btn2 = 1'b0;
        steps(57);
        chk("d2_left123", snooze_left2, 12'd123);
        #2 rst_n = 1'b0;
        #1;
        chk("d2_rst_state", 12'(state2), 12'd0);
        chk("d2_rst_buzz", 12'(buzzer2), 12'd0);
        chk("d2_rst_cnt", 12'(snooze_cnt2), 12'd0);
        chk("d2_rst_left", snooze_left2, 12'd0);
        #1 rst_n = 1'b1;
        step();
        chk("d2_post_rst_arm", 12'(state2), 12'd1);
        chk("post_rst_idle", 12'(state), 12'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alarm_snooze_ctrl.md
ALARM_SNOOZE_CTRL -- requirements
Module: alarm_snooze_ctrl

Interface
REQ-001 The block SHALL have parameters, one per line below; the bench overrides them only within the stated ranges.
- SNOOZE_MIN, 5, snooze length in minutes (1..63)
- RING_TIMEOUT, 60, seconds of ringing before automatic snooze (1..4095)
- MAX_SNOOZE, 3, snoozes allowed per alarm event (0..7)

REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  input  1  single clock; one rising edge per second
- rst_n  input  1  reset, asynchronous, active-low
- hr_24  input  5  current hour, 0..23
- min  input  6  current minute, 0..59
- sec  input  6  current second, 0..59
- alarm_hr  input  5  alarm hour, 0..23
- alarm_min  input  6  alarm minute, 0..59
- alarm_en  input  1  alarm armed when high
- snooze_btn  input  1  snooze request, level-sampled each edge
- stop_btn  input  1  stop request, level-sampled each edge
- buzzer  output  1  alarm sound drive
- state  output  2  00 IDLE, 01 ARMED, 10 RINGING, 11 SNOOZE
- snooze_cnt  output  3  snoozes used in the current event
- snooze_left  output  12  seconds remaining in SNOOZE, 0 otherwise

Function
REQ-003 The block SHALL define match = (hr_24==alarm_hr) && (min==alarm_min) && (sec==0), so that a match lasts one cycle per day.
REQ-004 In IDLE, alarm_en=1 SHALL move the block to ARMED on the next edge, and alarm_en=0 SHALL keep it in IDLE.
REQ-005 In ARMED, match SHALL move the block to RINGING, clear snooze_cnt and clear the ring-second counter on the same edge.
REQ-006 The block SHALL drive buzzer high from the edge on which it enters RINGING, with a latency of one edge after match is sampled, and SHALL hold it low in every other state.
REQ-007 In RINGING, stop_btn SHALL move the block to ARMED and clear snooze_cnt.
REQ-008 In RINGING, snooze_btn with snooze_cnt<MAX_SNOOZE SHALL move the block to SNOOZE, load snooze_left=SNOOZE_MIN*60 and increment snooze_cnt.
REQ-009 In RINGING, snooze_btn with snooze_cnt==MAX_SNOOZE SHALL be ignored.
REQ-010 In RINGING, the ring counter SHALL increment every edge; when it reaches RING_TIMEOUT-1, the next edge SHALL act as snooze_btn (REQ-008), or as stop_btn (REQ-007) if the snooze limit is reached.
REQ-011 In SNOOZE, snooze_left SHALL decrement every edge; at snooze_left==1 the next edge SHALL enter RINGING, set snooze_left=0, clear the ring counter and keep snooze_cnt.
REQ-012 In SNOOZE, stop_btn SHALL move the block to ARMED, set snooze_left=0 and clear snooze_cnt, while snooze_btn SHALL be ignored.
REQ-013 When stop_btn and snooze_btn are both high, stop SHALL win.
REQ-014 alarm_en=0 SHALL force IDLE from any state on the next edge, clearing buzzer, snooze_cnt and snooze_left, and SHALL take priority over all other inputs.
REQ-015 match occurring in RINGING or SNOOZE SHALL be ignored and SHALL not restart the event.
REQ-016 Changing alarm_hr or alarm_min mid-event SHALL not affect RINGING or SNOOZE.
REQ-017 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-018 rst_n=0 SHALL asynchronously force state=IDLE, buzzer=0, snooze_cnt=0, snooze_left=0, ring counter=0 and the pattern phase=0, including mid-RINGING and mid-SNOOZE.
REQ-019 After rst_n deasserts, the first edge SHALL follow REQ-004.

Configuration
REQ-020 With macro ALARM_BEEP_PATTERN_EN defined, buzzer in RINGING SHALL toggle every edge (1 on entry, then 0, 1, ...) and the pattern phase SHALL restart at 1 on each RINGING entry.
REQ-021 Without ALARM_BEEP_PATTERN_EN, buzzer SHALL be steady high throughout RINGING, and the block SHALL contain no phase register.

Verification
REQ-022 Arm, then hold alarm_en=1 with alarm 07:30 and time stepping 07:29:59 -> 07:30:00 -> next edge: state=RINGING, buzzer=1; at 07:30:01 without buttons, still ringing.
REQ-023 Ringing with snooze_btn for one edge and SNOOZE_MIN=1 -> state=SNOOZE, snooze_left=60, snooze_cnt=1; 60 edges later state=RINGING, buzzer=1.
REQ-024 MAX_SNOOZE=1, second snooze_btn while ringing -> ignored, buzzer stays 1; RING_TIMEOUT=10 with no buttons -> ARMED after 10 edges, buzzer=0.
REQ-025 stop_btn and snooze_btn high together in RINGING -> ARMED, snooze_cnt=0, snooze_left=0.
REQ-026 rst_n low mid-SNOOZE with snooze_left=123 -> IDLE and all outputs 0 immediately without a clock edge; alarm_en dropped in RINGING -> IDLE on the next edge.
REQ-027 With ALARM_BEEP_PATTERN_EN defined, 4 ringing edges -> buzzer 1,0,1,0; without it -> 1,1,1,1.
